// File: rtl/ps2_scan_decoder_if.sv
// Output bus of the PS/2 scan-code decoder.
//   pressedKey : last make code, bit8 = extended (E0-prefixed), bits7:0 = scan code
//   pressed    : one-fastClk pulse when pressedKey takes a new make code
//   frameError : one-fastClk pulse on framing, stop, timeout or parity error
// Modports: master = decoder (drives), slave = consumer (e.g. interrupt controller).
interface ps2_scan_decoder_if;
  logic [8:0] pressedKey;
  logic       pressed;
  logic       frameError;

  modport master (output pressedKey, output pressed, output frameError);
  modport slave  (input pressedKey, input pressed, input frameError);
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 device-to-host receiver and scan-code set 2 decoder.
// Ports:
//   fastClk  : sampling clock, all logic on posedge
//   rst      : synchronous, active-high reset
//   ps2CLK   : PS/2 clock line, only observed (left high-Z)
//   ps2DATA  : PS/2 data line, only observed (left high-Z)
//   bus      : ps2_scan_decoder_if.master (pressedKey, pressed, frameError)
// Optional feature: define PS2_PARITY_CHECK_EN to reject bytes failing odd parity.
// Without it the parity bit is consumed and ignored.
module ps2_scan_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                      fastClk,
  input  logic                      rst,
  inout  wire                       ps2CLK,
  inout  wire                       ps2DATA,
  ps2_scan_decoder_if.master        bus
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e        state;
  logic          clkS1, clkS2, datS1, datS2;
  logic          clkF, clkFPrev;
  logic [FW-1:0] filtCnt;
  logic [TW-1:0] toCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shreg;
  logic [7:0]    byteReg;
  logic          byteValid;
  logic          ext, brk;
`ifdef PS2_PARITY_CHECK_EN
  logic          parityBit;
`endif

  logic fe;
  assign fe = clkFPrev & ~clkF;

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state          <= StIdle;
      clkS1          <= 1'b1;
      clkS2          <= 1'b1;
      datS1          <= 1'b1;
      datS2          <= 1'b1;
      clkF           <= 1'b1;
      clkFPrev       <= 1'b1;
      filtCnt        <= '0;
      toCnt          <= '0;
      bitCnt         <= '0;
      shreg          <= '0;
      byteReg        <= '0;
      byteValid      <= 1'b0;
      ext            <= 1'b0;
      brk            <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parityBit      <= 1'b0;
`endif
      bus.pressedKey <= 9'h000;
      bus.pressed    <= 1'b0;
      bus.frameError <= 1'b0;
    end else begin
      clkS1 <= ps2CLK;
      clkS2 <= clkS1;
      datS1 <= ps2DATA;
      datS2 <= datS1;

      // Glitch filter: clkF follows clkS2 only after FILTER_LEN consecutive differing samples.
      if (clkS2 == clkF) begin
        filtCnt <= '0;
      end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
        clkF    <= clkS2;
        filtCnt <= '0;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
      clkFPrev <= clkF;

      bus.pressed    <= 1'b0;
      bus.frameError <= 1'b0;
      byteValid      <= 1'b0;

      if (fe || state == StIdle) begin
        toCnt <= '0;
      end else begin
        toCnt <= toCnt + 1'b1;
      end

      if (!fe && state != StIdle && toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state          <= StIdle;
        bus.frameError <= 1'b1;
        ext            <= 1'b0;
        brk            <= 1'b0;
      end else if (fe) begin
        unique case (state)
          StIdle: begin
            if (!datS2) begin
              bitCnt <= '0;
              state  <= StData;
            end else begin
              bus.frameError <= 1'b1;
            end
          end
          StData: begin
            shreg  <= {datS2, shreg[7:1]};
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) begin
              state <= StParity;
            end
          end
          StParity: begin
`ifdef PS2_PARITY_CHECK_EN
            parityBit <= datS2;
`endif
            state <= StStop;
          end
          StStop: begin
            state <= StIdle;
`ifdef PS2_PARITY_CHECK_EN
            if (!datS2) begin
              bus.frameError <= 1'b1;
            end else if (^{shreg, parityBit}) begin
              byteValid <= 1'b1;
              byteReg   <= shreg;
            end else begin
              bus.frameError <= 1'b1;
              ext            <= 1'b0;
              brk            <= 1'b0;
            end
`else
            if (datS2) begin
              byteValid <= 1'b1;
              byteReg   <= shreg;
            end else begin
              bus.frameError <= 1'b1;
            end
`endif
          end
        endcase
      end

      // Decoder runs the cycle after a valid byte; FSM is idle then, so no flag conflicts.
      if (byteValid) begin
        case (byteReg)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext <= 1'b0;
            brk <= 1'b0;
          end
          default: begin
            if (!brk) begin
              bus.pressedKey <= {ext, byteReg};
              bus.pressed    <= 1'b1;
            end
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

  localparam int FILT = 8;
  localparam int TO   = 400;
  localparam int HALF = 30;

  logic fastClk = 1'b0;
  logic rst     = 1'b1;
  logic clkDrv  = 1'b1;
  logic dataDrv = 1'b1;
  wire  ps2CLK;
  wire  ps2DATA;
  assign ps2CLK  = clkDrv;
  assign ps2DATA = dataDrv;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .fastClk(fastClk),
    .rst    (rst),
    .ps2CLK (ps2CLK),
    .ps2DATA(ps2DATA),
    .bus    (bus)
  );

  always #5 fastClk = ~fastClk;

  int nVec = 0;
  int nErr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor
  int   pressCnt = 0;
  int   errCnt   = 0;
  int   widthBad = 0;
  int   bothBad  = 0;
  logic prevPressed = 1'b0;

  always @(negedge fastClk) begin
    if (!rst) begin
      if (bus.pressed) pressCnt <= pressCnt + 1;
      if (bus.frameError) errCnt <= errCnt + 1;
      if (bus.pressed && prevPressed) widthBad <= widthBad + 1;
      if (bus.pressed && bus.frameError) bothBad <= bothBad + 1;
      prevPressed <= bus.pressed;
    end else begin
      prevPressed <= 1'b0;
    end
  end

  // Reference model: key state after a stream of valid bytes.
  logic [8:0] mKey = 9'h000;
  logic       mExt = 1'b0;
  logic       mBrk = 1'b0;

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic model_byte(input logic [7:0] b, output int expPulse);
    expPulse = 0;
    if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else begin
      if (!is_status(b) && !mBrk) begin
        mKey     = {mExt, b};
        expPulse = 1;
      end
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge fastClk);
  endtask

  // Drives nFalls clock periods of a frame; glitchBit selects a high phase to glitch (-1: none).
  task automatic send_frame(input logic [7:0] b, input logic startV, input logic parV,
                            input logic stopV, input int nFalls, input int glitchBit);
    logic [10:0] bits;
    bits = {stopV, parV, b, startV};
    for (int i = 0; i < nFalls; i++) begin
      dataDrv = bits[i];
      if (i == glitchBit) begin
        wait_cyc(5);
        clkDrv = 1'b0;
        wait_cyc(FILT - 1);
        clkDrv = 1'b1;
        wait_cyc(HALF - 5 - (FILT - 1));
      end else begin
        wait_cyc(HALF);
      end
      clkDrv = 1'b0;
      wait_cyc(HALF);
      clkDrv = 1'b1;
    end
    dataDrv = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input int glitchBit);
    int p0, e0, expPulse;
    p0 = pressCnt;
    e0 = errCnt;
    send_frame(b, 1'b0, ~^b, 1'b1, 11, glitchBit);
    wait_cyc(20);
    model_byte(b, expPulse);
    check({tag, "_pulse"}, pressCnt - p0, expPulse);
    check({tag, "_ferr"}, errCnt - e0, 0);
    check({tag, "_key"}, bus.pressedKey, mKey);
  endtask

  initial begin
    int p0, e0, r;
    logic [7:0] b;
    logic [7:0] statusTab [6];
    statusTab = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    wait_cyc(5);
    check("rst_key", bus.pressedKey, 9'h000);
    check("rst_pressed", bus.pressed, 0);
    check("rst_ferr", bus.frameError, 0);
    rst = 1'b0;
    wait_cyc(20);

    // Basic frame, prefixes, break codes
    frame_check("k1c", 8'h1C, -1);
    frame_check("e0", 8'hE0, -1);
    frame_check("e075", 8'h75, -1);
    frame_check("f0", 8'hF0, -1);
    frame_check("f01c", 8'h1C, -1);
    frame_check("e0b", 8'hE0, -1);
    frame_check("e0f0", 8'hF0, -1);
    frame_check("e0f075", 8'h75, -1);
    check("hold175", bus.pressedKey, 9'h175);

    // Glitches in idle and mid-data are rejected
    frame_check("gl_idle", 8'h1C, 0);
    frame_check("gl_data", 8'h1C, 4);
    frame_check("rep1c", 8'h1C, -1);

    // Truncated frame times out and clears the pending extended prefix
    frame_check("to_e0", 8'hE0, -1);
    p0 = pressCnt;
    e0 = errCnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 6, -1);
    wait_cyc(TO - 20 - HALF);
    check("to_early", errCnt - e0, 0);
    wait_cyc(120);
    check("to_pulse", errCnt - e0, 1);
    check("to_nopress", pressCnt - p0, 0);
    mExt = 1'b0;
    mBrk = 1'b0;
    frame_check("to_k23", 8'h23, -1);

    // Bad stop bit
    p0 = pressCnt;
    e0 = errCnt;
    send_frame(8'h1C, 1'b0, ~^8'h1C, 1'b0, 11, -1);
    wait_cyc(20);
    check("stop0_ferr", errCnt - e0, 1);
    check("stop0_nopress", pressCnt - p0, 0);
    check("stop0_key", bus.pressedKey, mKey);

    // Start bit of 1 seen in idle
    e0 = errCnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1, -1);
    wait_cyc(20);
    check("badstart_ferr", errCnt - e0, 1);

    // Reset mid-frame
    p0 = pressCnt;
    e0 = errCnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 5, -1);
    rst = 1'b1;
    wait_cyc(3);
    check("mrst_key", bus.pressedKey, 9'h000);
    check("mrst_pressed", bus.pressed, 0);
    check("mrst_ferr", bus.frameError, 0);
    rst = 1'b0;
    mKey = 9'h000;
    mExt = 1'b0;
    mBrk = 1'b0;
    wait_cyc(TO + 20);
    check("mrst_quiet", (pressCnt - p0) + (errCnt - e0), 0);
    frame_check("mrst_k1c", 8'h1C, -1);

    // Wrong parity
    p0 = pressCnt;
    e0 = errCnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11, -1);
    wait_cyc(20);
`ifdef PS2_PARITY_CHECK_EN
    check("par_ferr", errCnt - e0, 1);
    check("par_nopress", pressCnt - p0, 0);
    mExt = 1'b0;
    mBrk = 1'b0;
`else
    check("par_ferr", errCnt - e0, 0);
    check("par_press", pressCnt - p0, 1);
    mKey = 9'h01C;
`endif
    check("par_key", bus.pressedKey, mKey);

    // Randomized byte stream
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = statusTab[$urandom_range(0, 5)];
      else b = 8'($urandom_range(0, 255));
      frame_check($sformatf("rnd%0d_%02h", i, b), b, -1);
    end

    check("pulse_width", widthBad, 0);
    check("no_overlap", bothBad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
PS/2 device-to-host receiver and scan-code decoder. It sits directly upstream of the interrupt controller and runs on fastClk. It converts raw ps2CLK/ps2DATA frames (scan-code set 2) into a 9-bit key code plus a one-cycle pressed strobe. The interrupt controller stretches the strobe into the CPU clock domain.

Parameters:
FILTER_LEN, 8, number of consecutive equal fastClk samples required before the filtered ps2CLK level changes (glitch filter)
TIMEOUT_CYCLES, 50000, fastClk cycles without a falling ps2CLK edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
fastClk  input  1  sampling clock, all logic on posedge
rst  input  1  synchronous, active-high reset
ps2CLK  inout  1  PS/2 clock line; never driven, always high-Z
ps2DATA  inout  1  PS/2 data line; never driven, always high-Z
pressedKey  output  9  last make code; bit8 = extended (0xE0-prefixed), bits7:0 = scan code
pressed  output  1  one-fastClk pulse when pressedKey is updated with a new make code
frameError  output  1  one-fastClk pulse on framing, stop, timeout or (optionally) parity error

Behaviour:
- Reset, synchronous, active-high; clock fastClk. Reset values: pressedKey=9'h000, pressed=0, frameError=0, FSM=IDLE, ext/brk flags=0, filter output=1, synchronizers=1.
- Reset mid-frame discards partial data; no pulse is produced.
- Input conditioning:
  - ps2CLK and ps2DATA each pass through a 2-flop synchronizer.
  - Filtered clock clkF takes the synchronized value only after FILTER_LEN consecutive identical samples.
  - Falling edge fe = clkF_prev & ~clkF. Data is sampled only on fe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0 (start bit), clear bit counter and go to DATA. On fe with data=1, stay in IDLE and pulse frameError.
  - DATA: on fe, shift the bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, if data=1 the byte is valid; if data=0, pulse frameError and drop the byte. Return to IDLE in both cases.
- Timeout: a counter clears on every fe and increments while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, frameError pulses, and the ext/brk flags clear.
- Decoder, evaluated in the cycle after a valid byte:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: discard and clear ext/brk. No strobe.
  - Any other byte with brk=0: pressedKey <= {ext, byte}, pressed=1 for exactly one cycle, then clear ext/brk.
  - Any other byte with brk=1: no strobe, pressedKey unchanged, then clear ext/brk.
- Latency: pressed asserts exactly 2 fastClk cycles after the fe that samples the stop bit.
- pressedKey holds its value until the next make code.
- pressed and frameError are never asserted in the same cycle.
- Typed keys repeat as the keyboard resends the make code, and each resent make code pulses again. No auto-repeat suppression.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: in STOP, the byte is valid only if XOR(data[7:0], parity) = 1 (odd parity). A mismatch pulses frameError, clears ext/brk and produces no strobe.
- Undefined: the parity bit is sampled and ignored, and the byte validity check uses the stop bit only.

Test Plan:
1. Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 12.5 kHz -> pressed pulse width 1, pressedKey=9'h01C, frameError never asserted.
2. Bytes E0 then 75 -> single pressed pulse, pressedKey=9'h175. Then F0 1C and E0 F0 75 -> no pulse, pressedKey stays 9'h175.
3. ps2CLK low glitch of FILTER_LEN-1 cycles mid-idle and mid-DATA -> no bit sampled. A following valid 0x1C frame decodes to 9'h01C.
4. Frame of start + 5 bits then line idle -> frameError pulse TIMEOUT_CYCLES after the last fe. The next 0x23 frame -> pressedKey=9'h023.
5. Stop bit 0 on byte 0x1C -> frameError pulse, no pressed. rst asserted after 4 data bits -> outputs zero, and the next 0x1C frame decodes correctly.
6. 0x1C sent with parity 1 -> with PS2_PARITY_CHECK_EN: frameError pulse, no pressed. Without the macro: pressed pulse, pressedKey=9'h01C.
